countdown_ctrl: RTL and testbench

//  Control stage directly upstream of the DOWN_CNT digit chain of the countdown timer.

---
 rtl/countdown_ctrl.sv | 168 ++++++++++++++++
 tb/tb_countdown_ctrl.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/countdown_ctrl.sv
// countdown_ctrl
//   Control stage in front of the DOWN_CNT digit chain of a countdown timer.
//   It divides clk_i down to a tick, passes that tick to the counter chain as
//   cnt_ce_o only while the timer is running, and decodes the START/LOAD
//   buttons. It also watches zero_i to detect expiry and drives an alarm that
//   lasts a fixed number of ticks.
//
//   Ports
//     clk_i        system clock, rising edge
//     clr_i        synchronous active-high reset, overrides every other input
//     btn_start_i  1-cycle pulse: start / pause / resume / acknowledge alarm
//     btn_load_i   1-cycle pulse: reload the counter chain to its preset
//     zero_i       level from the registered counter chain: all digits == 0
//     cnt_ce_o     count enable to the least-significant DOWN_CNT, 1 cycle per tick
//     cnt_clr_o    registered 1-cycle reload pulse to every DOWN_CNT
//     running_o    high in RUN
//     alarm_o      high in ALARM
//     tick_o       1-cycle pulse at each prescaler wrap in RUN/ALARM (display blink)
//
//   state    | meaning
//   ---------+--------------------------------------------------------
//   ST_IDLE  | stopped, prescaler forced to 0, waiting for START/LOAD
//   ST_RUN   | prescaler counting, cnt_ce_o issued on every wrap
//   ST_PAUSE | prescaler frozen at its current value
//   ST_ALARM | counter expired, alarm held for ALARM_LEN ticks
module countdown_ctrl #(
    parameter int unsigned PRESCALE  = 100_000_000,
    parameter int unsigned ALARM_LEN = 10
) (
    input  logic clk_i,
    input  logic clr_i,
    input  logic btn_start_i,
    input  logic btn_load_i,
    input  logic zero_i,
    output logic cnt_ce_o,
    output logic cnt_clr_o,
    output logic running_o,
    output logic alarm_o,
    output logic tick_o
);

    localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int unsigned AW = $clog2(ALARM_LEN + 1);

    localparam logic [PW-1:0] PRESC_MAX  = PW'(PRESCALE - 1);
    localparam logic [AW-1:0] ALARM_LAST = AW'(ALARM_LEN - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_ALARM = 2'd3
    } state_t;

    state_t         state_q, state_d;
    logic [PW-1:0]  presc_q, presc_d;
    logic [AW-1:0]  alarm_cnt_q, alarm_cnt_d;
    logic           cnt_clr_q, cnt_clr_d;

    logic           presc_wrap;
    logic [PW-1:0]  presc_next;
    logic           start_eff;

    assign presc_wrap = (presc_q == PRESC_MAX);
    assign presc_next = presc_wrap ? '0 : presc_q + PW'(1);

    // LOAD takes priority: a START arriving together with LOAD is dropped.
    assign start_eff  = btn_start_i & ~btn_load_i;

    always_ff @(posedge clk_i) begin
        if (clr_i) begin
            state_q     <= ST_IDLE;
            presc_q     <= '0;
            alarm_cnt_q <= '0;
            cnt_clr_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            presc_q     <= presc_d;
            alarm_cnt_q <= alarm_cnt_d;
            cnt_clr_q   <= cnt_clr_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        presc_d     = presc_q;
        alarm_cnt_d = alarm_cnt_q;
        cnt_clr_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                presc_d     = '0;
                alarm_cnt_d = '0;
                if (btn_load_i) begin
                    cnt_clr_d = 1'b1;
                end else if (start_eff && !zero_i) begin
                    state_d = ST_RUN;
                end
            end

            ST_RUN: begin
                // Expiry beats everything; LOAD is ignored here, the user
                // has to pause first.
                if (zero_i) begin
                    state_d     = ST_ALARM;
                    presc_d     = '0;
                    alarm_cnt_d = '0;
                end else if (start_eff) begin
                    state_d = ST_PAUSE;
                end else begin
                    presc_d = presc_next;
                end
            end

            ST_PAUSE: begin
                if (btn_load_i) begin
                    state_d   = ST_IDLE;
                    presc_d   = '0;
                    cnt_clr_d = 1'b1;
                end else if (start_eff) begin
                    if (zero_i) begin
                        state_d = ST_IDLE;
                        presc_d = '0;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
            end

            ST_ALARM: begin
                if (btn_load_i) begin
                    state_d   = ST_IDLE;
                    presc_d   = '0;
                    cnt_clr_d = 1'b1;
                end else if (start_eff) begin
                    state_d = ST_IDLE;
                    presc_d = '0;
                end else begin
                    presc_d = presc_next;
                    if (presc_wrap) begin
                        if (alarm_cnt_q == ALARM_LAST) begin
                            state_d = ST_IDLE;
                            presc_d = '0;
                        end else begin
                            alarm_cnt_d = alarm_cnt_q + AW'(1);
                        end
                    end
                end
            end

            default: begin
                state_d     = ST_IDLE;
                presc_d     = '0;
                alarm_cnt_d = '0;
            end
        endcase
    end

    // The strobes are masked by clr_i in the same cycle, so a CE already
    // decoded from the registers never reaches the counter chain while the
    // block is being reset.
    assign cnt_ce_o  = ~clr_i & (state_q == ST_RUN) & presc_wrap & ~zero_i;
    assign tick_o    = ~clr_i & ((state_q == ST_RUN) | (state_q == ST_ALARM)) & presc_wrap;
    assign running_o = (state_q == ST_RUN);
    assign alarm_o   = (state_q == ST_ALARM);
    assign cnt_clr_o = cnt_clr_q;

endmodule

// File: tb/tb_countdown_ctrl.sv
module tb_countdown_ctrl;

    logic clk = 1'b0;
    logic clr;
    logic btn_start;
    logic btn_load;
    logic zero;
    logic cnt_ce;
    logic cnt_clr;
    logic running;
    logic alarm;
    logic tick;

    int cyc     = 0;
    int n_tests = 0;
    int n_fail  = 0;
    int cnt     = 3;
    bit mon_en  = 1'b0;

    typedef struct {
        int         c;
        logic [4:0] v;     // {ce, clr, running, alarm, tick}
        string      name;
    } exp_t;

    exp_t exp_q[$];

    countdown_ctrl #(.PRESCALE(4), .ALARM_LEN(3)) dut (
        .clk_i       (clk),
        .clr_i       (clr),
        .btn_start_i (btn_start),
        .btn_load_i  (btn_load),
        .zero_i      (zero),
        .cnt_ce_o    (cnt_ce),
        .cnt_clr_o   (cnt_clr),
        .running_o   (running),
        .alarm_o     (alarm),
        .tick_o      (tick)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Environment: DOWN_CNT chain reduced to one counter preset to 3.
    always @(posedge clk) begin
        if (cnt_clr)
            cnt <= 3;
        else if (cnt_ce && cnt != 0)
            cnt <= cnt - 1;
    end
    assign zero = (cnt == 0);

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) step();
    endtask

    task automatic push(input int c, input logic [4:0] v, input string n);
        exp_t e;
        e.c = c;
        e.v = v;
        e.name = n;
        exp_q.push_back(e);
    endtask

    task automatic check_quiet(input string n);
        n_tests++;
        if ({cnt_ce, cnt_clr, running, alarm, tick} !== 5'b00000) begin
            n_fail++;
            $display("FAIL %s: outputs {ce,clr,run,alarm,tick}=%b required 00000", n,
                     {cnt_ce, cnt_clr, running, alarm, tick});
        end
    endtask

    // Monitor: an output event is any strobe high or a change of RUNNING/ALARM.
    logic prev_run = 1'b0;
    logic prev_al  = 1'b0;
    always @(negedge clk) begin
        if (mon_en) begin
            if (cnt_ce || cnt_clr || tick || running !== prev_run || alarm !== prev_al) begin
                n_tests++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_event: cyc=%0d {ce,clr,run,alarm,tick}=%b required no event",
                             cyc, {cnt_ce, cnt_clr, running, alarm, tick});
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    if (e.c != cyc || e.v !== {cnt_ce, cnt_clr, running, alarm, tick}) begin
                        n_fail++;
                        $display("FAIL %s: got cyc=%0d outputs=%b required cyc=%0d outputs=%b",
                                 e.name, cyc, {cnt_ce, cnt_clr, running, alarm, tick}, e.c, e.v);
                    end
                end
            end
            prev_run = running;
            prev_al  = alarm;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached at cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int r;
        int r2;
        int r3;

        // Reset held two cycles with random button activity.
        clr       = 1'b1;
        btn_start = 1'($urandom_range(0, 1));
        btn_load  = 1'($urandom_range(0, 1));
        step();
        mon_en = 1'b1;
        check_quiet("clr_cycle1");
        btn_start = 1'($urandom_range(0, 1));
        btn_load  = 1'($urandom_range(0, 1));
        step();
        check_quiet("clr_cycle2");
        clr       = 1'b0;
        btn_start = 1'b0;
        btn_load  = 1'b0;
        step();
        check_quiet("idle_after_clr");

        // Start, CE on the 4th RUN cycle and every 4 after.
        btn_start = 1'b1;
        push(cyc + 1, 5'b00100, "start_run");
        step();
        btn_start = 1'b0;
        r = cyc;
        push(r + 3, 5'b10101, "first_ce");

        // Pause at presc=2, hold 10 cycles, resume: CE two cycles after START.
        wait_until(r + 6);
        btn_start = 1'b1;
        push(r + 7, 5'b00000, "pause");
        step();
        btn_start = 1'b0;
        wait_until(r + 17);
        btn_start = 1'b1;
        push(r + 18, 5'b00100, "resume");
        push(r + 19, 5'b10101, "ce_after_resume");
        push(r + 23, 5'b10101, "third_ce");
        // Expiry: ALARM two cycles after the last CE, three ticks, then IDLE.
        push(r + 25, 5'b00010, "alarm_on");
        push(r + 28, 5'b00011, "alarm_tick1");
        push(r + 32, 5'b00011, "alarm_tick2");
        push(r + 36, 5'b00011, "alarm_tick3");
        push(r + 37, 5'b00000, "alarm_off");
        step();
        btn_start = 1'b0;
        wait_until(r + 40);

        // START with ZERO=1 in IDLE is ignored.
        btn_start = 1'b1;
        step();
        btn_start = 1'b0;
        step();
        step();

        // LOAD in IDLE reloads the counter.
        btn_load = 1'b1;
        push(cyc + 1, 5'b01000, "idle_load");
        step();
        btn_load = 1'b0;
        step();

        // RUN -> PAUSE, then LOAD+START together: reload pulse and IDLE.
        btn_start = 1'b1;
        push(cyc + 1, 5'b00100, "t5_run");
        step();
        push(cyc + 1, 5'b00000, "t5_pause");
        step();
        btn_start = 1'b0;
        step();
        step();
        step();
        btn_start = 1'b1;
        btn_load  = 1'b1;
        push(cyc + 1, 5'b01000, "pause_load_start");
        step();
        btn_start = 1'b0;
        btn_load  = 1'b0;
        step();
        step();

        // CLR in RUN while presc=3: CE masked, IDLE, restart counts from 0.
        btn_start = 1'b1;
        push(cyc + 1, 5'b00100, "t6_run");
        step();
        btn_start = 1'b0;
        r2 = cyc;
        wait_until(r2 + 3);
        clr = 1'b1;
        push(r2 + 4, 5'b00000, "clr_mid_run");
        step();
        clr = 1'b0;
        step();
        btn_start = 1'b1;
        push(cyc + 1, 5'b00100, "restart_run");
        step();
        btn_start = 1'b0;
        r3 = cyc;
        push(r3 + 3, 5'b10101, "restart_ce1");
        push(r3 + 7, 5'b10101, "restart_ce2");
        wait_until(r3 + 8);
        btn_start = 1'b1;
        push(r3 + 9, 5'b00000, "final_pause");
        step();
        btn_start = 1'b0;
        repeat (6) step();

        while (exp_q.size() != 0) begin
            exp_t e;
            e = exp_q.pop_front();
            n_tests++;
            n_fail++;
            $display("FAIL %s: event missing, required cyc=%0d outputs=%b", e.name, e.c, e.v);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
